// File: rtl/motor_pwm_pkg.sv
// Shared definitions for the multi-channel H-bridge PWM bank.
package motor_pwm_pkg;

  typedef enum logic [1:0] {
    MODE_COAST = 2'b00,
    MODE_FWD   = 2'b01,
    MODE_REV   = 2'b10,
    MODE_BRAKE = 2'b11
  } mode_e;

  // Last counter value of a PWM period; the period is 2^w-1 cycles long.
  function automatic int unsigned pwm_max(input int unsigned w);
    return (32'd1 << w) - 32'd2;
  endfunction

endpackage

// File: rtl/motor_pwm_channel.sv
// One H-bridge channel: pending/active config, RUN/DEAD FSM, registered drive.
module motor_pwm_channel
  import motor_pwm_pkg::*;
#(
  parameter int unsigned PWM_W  = 8,
  parameter int unsigned DEAD_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              wrap,
  input  logic [PWM_W-1:0]  cnt,
  input  logic [DEAD_W-1:0] dead_time,
  input  logic              wr,
  input  logic [PWM_W-1:0]  wr_duty,
  input  logic [1:0]        wr_mode,
  output logic              pending_full,
  output logic              motor_pos,
  output logic              motor_neg
);

  typedef enum logic {ST_RUN, ST_DEAD} state_e;

  state_e            state;
  logic [DEAD_W-1:0] dcnt;
  logic [PWM_W-1:0]  pend_duty;
  logic [PWM_W-1:0]  act_duty;
  mode_e             pend_mode;
  mode_e             act_mode;
  logic              load_now;
  logic              load;
  logic [PWM_W-1:0]  new_duty;
  mode_e             new_mode;
  logic              pwm;

  assign load_now = !en || wrap;
  assign pwm      = (cnt < act_duty);

  // Select what (if anything) moves into the active registers this cycle;
  // an empty slot lets a write landing on a load cycle bypass straight in.
  always_comb begin
    load     = 1'b0;
    new_duty = pend_duty;
    new_mode = pend_mode;
    if (load_now) begin
      if (pending_full) begin
        load = 1'b1;
      end else if (wr) begin
        load     = 1'b1;
        new_duty = wr_duty;
        new_mode = mode_e'(wr_mode);
      end
    end
  end

  // Depth-1 pending slot; drained on every load cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_full <= 1'b0;
      pend_duty    <= '0;
      pend_mode    <= MODE_COAST;
    end else if (load_now) begin
      pending_full <= 1'b0;
    end else if (wr) begin
      pending_full <= 1'b1;
      pend_duty    <= wr_duty;
      pend_mode    <= mode_e'(wr_mode);
    end
  end

  // Active config, RUN/DEAD sequencing and registered bridge outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_duty  <= '0;
      act_mode  <= MODE_COAST;
      state     <= ST_RUN;
      dcnt      <= '0;
      motor_pos <= 1'b0;
      motor_neg <= 1'b0;
    end else begin
      if (load) begin
        act_duty <= new_duty;
        act_mode <= new_mode;
      end

      // Dead intervals only matter while driving; disabling drops back to RUN.
      if (!en) begin
        state <= ST_RUN;
        dcnt  <= '0;
      end else if (load && (new_mode != act_mode) && (dead_time != '0)) begin
        state <= ST_DEAD;
        dcnt  <= dead_time;
      end else if (state == ST_DEAD) begin
        if (dcnt == DEAD_W'(1)) begin
          state <= ST_RUN;
        end else begin
          dcnt <= dcnt - DEAD_W'(1);
        end
      end

      if (!en || (state == ST_DEAD)) begin
        motor_pos <= 1'b0;
        motor_neg <= 1'b0;
      end else begin
        case (act_mode)
          MODE_FWD: begin
            motor_pos <= pwm;
            motor_neg <= 1'b0;
          end
          MODE_REV: begin
            motor_pos <= 1'b0;
            motor_neg <= pwm;
          end
          MODE_BRAKE: begin
            motor_pos <= 1'b1;
            motor_neg <= 1'b1;
          end
          default: begin
            motor_pos <= 1'b0;
            motor_neg <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/motor_pwm_bank.sv
// Multi-channel H-bridge PWM driver: shared period counter, cfg port, channels.
module motor_pwm_bank
  import motor_pwm_pkg::*;
#(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned PWM_W  = 8,
  parameter int unsigned DEAD_W = 4,
  localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [DEAD_W-1:0] dead_time,
  input  logic              cfg_valid,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [PWM_W-1:0]  cfg_duty,
  input  logic [1:0]        cfg_mode,
  output logic              cfg_ready,
  output logic              period_start,
  output logic [NUM_CH-1:0] motor_pos,
  output logic [NUM_CH-1:0] motor_neg
);

  localparam logic [PWM_W-1:0] CNT_MAX = PWM_W'(pwm_max(PWM_W));

  logic [PWM_W-1:0]     cnt;
  logic                 wrap;
  logic [NUM_CH-1:0]    pending_full;
  logic [2**CH_W-1:0]   ready_vec;

  assign wrap = en && (cnt == CNT_MAX);

  // Ready mux; unpopulated channel codes never accept a write.
  always_comb begin
    ready_vec               = '0;
    ready_vec[NUM_CH-1:0]   = ~pending_full;
    cfg_ready               = ready_vec[cfg_ch];
  end

  // Shared period counter, parked at zero while disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!en || wrap) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + PWM_W'(1);
    end
  end

  // Period marker, registered so it lines up with the first output cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_start <= 1'b0;
    end else begin
      period_start <= en && (cnt == '0);
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic wr;
    assign wr = cfg_valid && cfg_ready && (cfg_ch == CH_W'(i));

    motor_pwm_channel #(
      .PWM_W  (PWM_W),
      .DEAD_W (DEAD_W)
    ) u_ch (
      .clk          (clk),
      .rst_n        (rst_n),
      .en           (en),
      .wrap         (wrap),
      .cnt          (cnt),
      .dead_time    (dead_time),
      .wr           (wr),
      .wr_duty      (cfg_duty),
      .wr_mode      (cfg_mode),
      .pending_full (pending_full[i]),
      .motor_pos    (motor_pos[i]),
      .motor_neg    (motor_neg[i])
    );
  end

endmodule

// File: doc/motor_pwm_bank.md
Name: motor_pwm_bank

Overview:
- Parametrised multi-channel H-bridge PWM driver. Successor to the single-channel motor_positive/motor_negative output stage.
- Each channel has a configurable duty, a mode (coast/forward/reverse/brake) and double-buffered config that takes effect only at the period boundary.
- Programmable dead time is inserted on every mode change.
- Sits between the register/I2C front end (cfg writes) and the pads.

Parameters:
- NUM_CH, 2, number of independent motor channels (1..8)
- PWM_W, 8, duty/counter width; period = 2^PWM_W-1 cycles
- DEAD_W, 4, width of dead-time count

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  global enable; low forces all outputs low
- dead_time  in  DEAD_W  dead-time length in cycles, sampled when a dead interval starts
- cfg_valid  in  1  config write request
- cfg_ch  in  max(1,$clog2(NUM_CH))  target channel
- cfg_duty  in  PWM_W  requested duty
- cfg_mode  in  2  00 coast, 01 fwd, 10 rev, 11 brake
- cfg_ready  out  1  write accepted when cfg_valid&&cfg_ready
- period_start  out  1  one-cycle pulse aligned with first output cycle of each period
- motor_pos  out  NUM_CH  H-bridge positive drive
- motor_neg  out  NUM_CH  H-bridge negative drive

Behaviour:
- Reset (async, rst_n=0):
  - cnt=0.
  - All active and pending regs = coast/duty 0; pending_full=0.
  - All channels in RUN state.
  - motor_pos, motor_neg and period_start = 0 immediately.
- Counter:
  - Shared cnt runs 0..MAX, where MAX=2^PWM_W-2, then wraps to 0.
  - Held at 0 while en=0.
- Wrap cycle = cycle with cnt==MAX and en=1.
- Compare: pwm=(cnt<duty_active).
  - duty 0 gives always off.
  - duty 2^PWM_W-1 gives always on.
- Outputs are registered: value on cycle t+1 reflects cnt and state at cycle t. period_start is registered from (cnt==0 && en).
- Mode mapping (RUN state):
  - coast: 0/0
  - fwd: pos=pwm, neg=0
  - rev: pos=0, neg=pwm
  - brake: 1/1, duty ignored
- Per-channel pending slot (depth 1):
  - cfg_ready = !pending_full[cfg_ch] (combinational). This makes cfg_ready combinationally dependent on cfg_ch; the requester must hold cfg_ch stable while cfg_valid is high.
  - An accepted write stores duty/mode and sets pending_full.
- Load into active registers:
  - On a wrap cycle, each channel with pending_full copies pending into active and clears pending_full. pending_full is still 1 during that cycle, so cfg_ready for that channel stays 0.
  - A write accepted on a wrap cycle to a channel with empty pending bypasses straight into active.
  - While en=0, loads happen every cycle (immediate apply).
- Dead time (per channel, states RUN/DEAD):
  - Trigger: a load where new mode != old mode and dead_time!=0. Enter DEAD with dcnt=dead_time; outputs 0/0.
  - Each cycle dcnt decrements; at dcnt==1 the channel returns to RUN. Outputs are low for exactly dead_time cycles starting at the first cycle of the new period.
  - A new mode-changing load during DEAD restarts dcnt.
  - A load with the same mode changes duty only; there is no dead interval.
- en falling edge: outputs 0 on the next cycle; cnt=0; DEAD states are cleared to RUN.
- en rising edge: first output cycle has period_start=1.
- Simultaneous writes are impossible: there is a single cfg port. Writes to different channels in consecutive cycles are all accepted.

Decomposition:
- Package motor_pwm_pkg: mode constants MODE_COAST/FWD/REV/BRAKE (2-bit) and a localparam function for MAX.
- Sub-module motor_pwm_channel: pending/active regs, RUN/DEAD FSM, dead counter, output flops.
- Top: shared counter, cfg demux/ready mux, period_start; instantiates motor_pwm_channel NUM_CH times via generate.

Test Plan:
- Reset, en=1, dead_time=0, write ch0 duty=64 fwd → from the period after the next wrap, motor_pos[0] high 64 of every 255 cycles; motor_neg[0]=0; period_start every 255 cycles.
- ch0 duty=0 fwd → motor_pos[0] never high. Then duty=255 → motor_pos[0] high all 255 cycles of the period.
- ch0 fwd duty=128, then write rev duty=128 with dead_time=5 → at the boundary both outputs 0 for exactly 5 cycles, then motor_neg[0] high until period cycle 128, motor_pos[0] stays 0.
- Two writes to ch1 within one period → first accepted; cfg_ready=0 for ch1 until after the wrap cycle; the second is accepted the cycle after the wrap and applies at the following wrap. A write to ch0 meanwhile is accepted immediately.
- ch1 brake duty=10 → pos=neg=1 all cycles. Drop en mid-period → outputs 0 next cycle, cnt=0; write while en=0 takes effect immediately.
- Assert rst_n=0 during a DEAD interval while outputs are in brake/pwm → all outputs 0 asynchronously; after release, coast on every channel and cfg_ready=1.
